// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle for alu_pipe.
//   Optional sat signal is present only when ALU_SAT_EN is defined.
//   Handshake rule on both sides: a beat transfers on a rising clk edge
//   where valid && ready. The master holds its payload and valid until that
//   edge. ready may depend on the other side's ready, never on valid.
interface alu_pipe_if #(parameter int W = 16);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   Op;
`ifdef ALU_SAT_EN
  logic         sat;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic [3:0]   flags;

  // Issue side plus result consumer (test or surrounding logic).
  modport master (
`ifdef ALU_SAT_EN
    output sat,
`endif
    output in_valid, A, B, Op, out_ready,
    input  in_ready, out_valid, y, flags
  );

  // The ALU itself.
  modport slave (
`ifdef ALU_SAT_EN
    input  sat,
`endif
    input  in_valid, A, B, Op, out_ready,
    output in_ready, out_valid, y, flags
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with a valid/ready handshake on both sides.
//   Stage 1 registers the operand beat. Stage 2 registers the result and the
//   {Z,N,C,V} flags. It sustains one op per cycle, and up to two beats can be
//   in flight.
//   Optional feature: ALU_SAT_EN adds a sat input. With sat set, ADD and SUB
//   clamp to the signed limits on overflow.
module alu_pipe #(
  parameter int W = 16
) (
  input  logic      clk,
  input  logic      reset,
  alu_pipe_if.slave bus
);

  localparam int SHW = $clog2(W);
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SRA = 3'b111
  } op_e;

  // Stage 1 holding registers.
  logic         s1_v;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;
  op_e          s1_op;
`ifdef ALU_SAT_EN
  logic         s1_sat;
`endif

  logic s2_adv;
  logic s1_adv;
  logic accept;

  // Stage 2 may load when it is empty or its result leaves this cycle.
  // Stage 1 may take a new beat when it is empty or it is moving into stage 2.
  assign s2_adv       = !bus.out_valid || bus.out_ready;
  assign s1_adv       = s1_v && s2_adv;
  assign bus.in_ready = !s1_v || s2_adv;
  assign accept       = bus.in_valid && bus.in_ready;

  // Execute datapath. Each W+1 bit extension carries the last bit shifted out
  // (or the carry/borrow) in its extra bit.
  logic [SHW-1:0] amt;
  logic [W:0]     add_ext;
  logic [W:0]     sub_ext;
  logic [W:0]     sll_ext;
  logic [W:0]     srl_ext;
  logic [W:0]     sra_ext;
  logic [W-1:0]   res_y;
  logic           res_c;
  logic           res_v;

  // Compute the result and the C/V flags for the op held in stage 1.
  always_comb begin
    amt     = s1_b[SHW-1:0];
    add_ext = {1'b0, s1_a} + {1'b0, s1_b};
    sub_ext = {1'b0, s1_a} - {1'b0, s1_b};
    sll_ext = {1'b0, s1_a} << amt;
    srl_ext = {s1_a, 1'b0} >> amt;
    sra_ext = (W+1)'($signed({s1_a, 1'b0}) >>> amt);
    res_y   = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res_y = add_ext[W-1:0];
        res_c = add_ext[W];
        res_v = (s1_a[W-1] == s1_b[W-1]) && (add_ext[W-1] != s1_a[W-1]);
      end
      OP_SUB: begin
        res_y = sub_ext[W-1:0];
        res_c = !sub_ext[W];
        res_v = (s1_a[W-1] != s1_b[W-1]) && (sub_ext[W-1] != s1_a[W-1]);
      end
      OP_AND: res_y = s1_a & s1_b;
      OP_OR:  res_y = s1_a | s1_b;
      OP_XOR: res_y = s1_a ^ s1_b;
      OP_SLL: begin
        res_y = sll_ext[W-1:0];
        res_c = sll_ext[W];
      end
      OP_SRL: begin
        res_y = srl_ext[W:1];
        res_c = srl_ext[0];
      end
      OP_SRA: begin
        res_y = sra_ext[W:1];
        res_c = sra_ext[0];
      end
      default: res_y = '0;
    endcase
`ifdef ALU_SAT_EN
    // The sign of A gives the overflow direction for both ADD and SUB.
    if (s1_sat && res_v && (s1_op == OP_ADD || s1_op == OP_SUB))
      res_y = s1_a[W-1] ? SMIN : SMAX;
`endif
  end

  // Stage 1: capture an accepted beat, or empty out when the beat moves on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v   <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_op  <= OP_ADD;
`ifdef ALU_SAT_EN
      s1_sat <= 1'b0;
`endif
    end else if (accept) begin
      s1_v   <= 1'b1;
      s1_a   <= bus.A;
      s1_b   <= bus.B;
      s1_op  <= op_e'(bus.Op);
`ifdef ALU_SAT_EN
      s1_sat <= bus.sat;
`endif
    end else if (s1_adv) begin
      s1_v <= 1'b0;
    end
  end

  // Stage 2: register the result and flags. Everything holds during a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.y         <= '0;
      bus.flags     <= '0;
    end else if (s2_adv) begin
      bus.out_valid <= s1_v;
      if (s1_adv) begin
        bus.y     <= res_y;
        bus.flags <= {(res_y == '0), res_y[W-1], res_c, res_v};
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized and directed bench for alu_pipe (W=16).
//   Expected results come from an arithmetic reference model and are queued
//   in acceptance order.
module tb_alu_pipe;
  localparam int W = 16;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_pipe_if #(.W(W)) bus ();

  alu_pipe #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state: expected {y, Z, N, C, V} per in-flight beat.
  logic [W+3:0] exp_q[$];
  logic         prev_stall;
  logic [W-1:0] prev_y;
  logic [3:0]   prev_f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: signed/unsigned integer arithmetic on 64-bit values.
  function automatic logic [W+3:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic s);
    longint m, ua, ub, sa, sb, r, sr, smax, smin, n;
    logic c, v;
    logic [W-1:0] y;
    m    = longint'(1) << W;
    smax = (m / 2) - 1;
    smin = -(m / 2);
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    n    = ub % (longint'(1) << $clog2(W));
    c    = 1'b0;
    v    = 1'b0;
    r    = 0;
    case (op)
      3'd0: begin
        r  = ua + ub;
        sr = sa + sb;
        c  = (r >= m);
        v  = (sr > smax) || (sr < smin);
        if (s && v) r = (sr > smax) ? smax : smin;
      end
      3'd1: begin
        r  = ua - ub;
        sr = sa - sb;
        c  = (ua >= ub);
        v  = (sr > smax) || (sr < smin);
        if (s && v) r = (sr > smax) ? smax : smin;
      end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: begin
        r = ua << n;
        c = (n != 0) && (((ua >> (W - n)) & 1) != 0);
      end
      3'd6: begin
        r = ua >> n;
        c = (n != 0) && (((ua >> (n - 1)) & 1) != 0);
      end
      default: begin
        r = sa >>> n;
        c = (n != 0) && (((sa >>> (n - 1)) & 1) != 0);
      end
    endcase
    r = ((r % m) + m) % m;
    y = W'(r);
    return {y, (r == 0), (r >= m / 2), c, v};
  endfunction

  function automatic logic cur_sat();
`ifdef ALU_SAT_EN
    return bus.sat;
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle. The caller sets inputs at the negedge. After they settle,
  // this checks the handshake and consumed data, records any accept, and
  // returns at the next negedge.
  task automatic step(output bit acc, output bit cons);
    logic [W+3:0] e;
    logic exp_rdy;
    #1;
    exp_rdy = !(exp_q.size() >= 2 && !bus.out_ready);
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (prev_stall) begin
      check("hold_valid", 32'(bus.out_valid), 32'(1));
      check("hold_y", 32'(bus.y), 32'(prev_y));
      check("hold_flags", 32'(bus.flags), 32'(prev_f));
    end
    cons = bus.out_valid && bus.out_ready;
    if (cons) begin
      if (exp_q.size() == 0) begin
        check("out_valid_spurious", 32'(bus.out_valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("y", 32'(bus.y), 32'(e[W+3:4]));
        check("flags", 32'(bus.flags), 32'(e[3:0]));
      end
    end
    acc = bus.in_valid && bus.in_ready;
    if (acc) exp_q.push_back(model(bus.Op, bus.A, bus.B, cur_sat()));
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_y     = bus.y;
    prev_f     = bus.flags;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a beat and hold it until it is accepted, within a cycle bound.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s);
    bit acc, cons;
    bus.in_valid = 1'b1;
    bus.Op = op;
    bus.A  = a;
    bus.B  = b;
`ifdef ALU_SAT_EN
    bus.sat = s;
`else
    if (s) $display("note: sat requested without ALU_SAT_EN");
`endif
    for (int i = 0; i < 50; i++) begin
      step(acc, cons);
      if (acc) return;
    end
    check("send_timeout", 32'(bus.in_ready), 32'(1));
  endtask

  // A single op through an empty pipe with a known result.
  task automatic run_one(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] ey, input logic [3:0] ef);
    bit acc, cons;
    int lat;
    bus.out_ready = 1'b1;
    send(op, a, b, s);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 10) begin
      step(acc, cons);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(1));
    check({tag, "_y"}, 32'(bus.y), 32'(ey));
    check({tag, "_flags"}, 32'(bus.flags), 32'(ef));
    step(acc, cons);
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] specials[5];
    specials = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return W'($urandom);
  endfunction

  // Main sequence.
  initial begin
    bit acc, cons;
    int n_acc, n_cons;
    logic [W-1:0] ba[4];
    logic [W-1:0] bb[4];
    logic [2:0]   bo[4];
    checks = 0;
    failures = 0;
    prev_stall = 1'b0;
    prev_y = '0;
    prev_f = '0;
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Op = '0;
    bus.out_ready = 1'b0;
`ifdef ALU_SAT_EN
    bus.sat = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_y", 32'(bus.y), 32'(0));
    check("rst_flags", 32'(bus.flags), 32'(0));
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    @(negedge clk);
    reset = 1'b0;
    step(acc, cons);

    // Known-answer ops.
    run_one("add_ovf", 3'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0101);
    run_one("sub_zero", 3'd1, 16'h0005, 16'h0005, 1'b0, 16'h0000, 4'b1010);
    run_one("sub_borrow", 3'd1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b0100);
    run_one("sra4", 3'd7, 16'h8001, 16'h0004, 1'b0, 16'hF800, 4'b0100);
    run_one("sll1", 3'd5, 16'h8001, 16'h0001, 1'b0, 16'h0002, 4'b0010);
    run_one("srl0", 3'd6, 16'h1234, 16'h0000, 1'b0, 16'h1234, 4'b0000);
`ifdef ALU_SAT_EN
    run_one("sat_add", 3'd0, 16'h7FFF, 16'h0001, 1'b1, 16'h7FFF, 4'b0001);
    run_one("sat_sub", 3'd1, 16'h8000, 16'h0001, 1'b1, 16'h8000, 4'b0111);
    run_one("wrap_sub", 3'd1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b0011);
`endif

    // Backpressure: four beats offered while the consumer stalls.
    for (int i = 0; i < 4; i++) begin
      ba[i] = rand_operand();
      bb[i] = rand_operand();
      bo[i] = 3'($urandom_range(0, 7));
    end
    bus.out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.A = ba[n_acc];
      bus.B = bb[n_acc];
      bus.Op = bo[n_acc];
      step(acc, cons);
      if (acc) n_acc++;
    end
    check("stall_accepts", 32'(n_acc), 32'(2));
    check("stall_in_ready", 32'(bus.in_ready), 32'(0));
    bus.out_ready = 1'b1;
    n_cons = 0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = (n_acc < 4);
      if (n_acc < 4) begin
        bus.A = ba[n_acc];
        bus.B = bb[n_acc];
        bus.Op = bo[n_acc];
      end
      step(acc, cons);
      if (acc) n_acc++;
      if (cons) n_cons++;
    end
    check("release_accepts", 32'(n_acc), 32'(4));
    check("release_rate", 32'(n_cons), 32'(4));

    // Reset with two beats in flight.
    bus.out_ready = 1'b0;
    send(3'd2, 16'hAAAA, 16'h0F0F, 1'b0);
    send(3'd3, 16'h1111, 16'h2222, 1'b0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("flush_out_valid", 32'(bus.out_valid), 32'(0));
    check("flush_y", 32'(bus.y), 32'(0));
    check("flush_flags", 32'(bus.flags), 32'(0));
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("flush_in_ready", 32'(bus.in_ready), 32'(1));
    @(negedge clk);
    run_one("post_rst_add", 3'd0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000);
    check("post_rst_empty", 32'(exp_q.size()), 32'(0));

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 500; i++) begin
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.A = rand_operand();
      bus.B = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, W - 1)) : rand_operand();
      bus.Op = 3'($urandom_range(0, 7));
`ifdef ALU_SAT_EN
      bus.sat = 1'($urandom_range(0, 1));
`endif
      bus.out_ready = ($urandom_range(0, 9) < 7);
      step(acc, cons);
    end

    // Drain.
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(acc, cons);
    check("drain_empty", 32'(exp_q.size()), 32'(0));
    step(acc, cons);
    check("drain_out_valid", 32'(bus.out_valid), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
